rx_drain_ctrl: RTL and testbench
================================

Name: rx_drain_ctrl

Overview:
- Controller on the host side of the UART receive block.
- Drains received bytes from the receiver's data buffer using its data_ready/data_read handshake and stores them in a small internal FIFO.
- Presents the bytes to a downstream consumer through a valid/ready interface.
- Keeps sticky framing/overrun status, so the receiver is serviced promptly even when the consumer stalls.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH+1), width of fifo_count.

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- rx_data  in  8  received byte from receiver buffer
- data_ready  in  1  receiver buffer holds an unread byte
- overrun_error  in  1  receiver overrun flag (level)
- framing_error  in  1  receiver framing flag (level)
- data_read  out  1  one-cycle pulse: receiver buffer consumed
- out_data  out  8  FIFO head byte
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data this cycle
- fifo_count  out  CNT_W  bytes currently held
- err_clear  in  1  clears sticky error flags
- framing_sticky  out  1  a framing error has been seen since the last clear
- overrun_sticky  out  1  an overrun has been seen since the last clear

Behaviour:
- Reset (asynchronous, n_rst=0):
  - state=IDLE; data_read=0; out_valid=0; out_data=0; fifo_count=0.
  - Both sticky flags are 0; FIFO pointers are 0.
  - Reset applied mid-transfer discards FIFO contents and any pending data_read pulse.
- FSM states: IDLE, READ, WAIT.
- IDLE:
  - If data_ready=1 and the FIFO is not full, rx_data is written into the FIFO on that edge and the FSM goes to READ.
  - Otherwise the FSM stays in IDLE.
- READ:
  - data_read=1 (registered output, exactly one cycle).
  - The FSM goes to WAIT unconditionally.
- WAIT:
  - data_read=0.
  - Returns to IDLE on the first cycle with data_ready=0. This prevents a double read while the receiver clears its buffer.
- Full-FIFO handling:
  - The full test uses the current count only; a same-cycle pop does not free space for a push.
  - While full, data_ready is left pending. The receiver then overruns naturally and overrun_sticky records it.
- Latency:
  - data_ready sampled high at edge N gives out_valid=1 and data_read=1 in cycle N+1 (FIFO previously empty).
  - Minimum spacing between captures is 3 cycles.
- FIFO:
  - Circular buffer with pointers of $clog2(DEPTH)+1 bits; full/empty are distinguished by the MSB, and pointers wrap modulo 2*DEPTH.
  - Pop occurs when out_valid and out_ready are both 1.
  - Push and pop in the same cycle (non-full, non-empty) leave the count unchanged.
  - out_data is the head entry (combinational read); it is 0 when empty.
  - out_ready while empty has no effect.
- Sticky flags:
  - A flag sets on any cycle its input level is 1.
  - err_clear=1 clears it; if set and clear happen in the same cycle, set wins.
- No arithmetic beyond pointer increments and the count. fifo_count is always in the range 0..DEPTH.

Optional Feature:
- Macro: RX_DRAIN_ERR_CNT_EN.
- Defined: adds outputs framing_cnt[7:0] and overrun_cnt[7:0].
  - Each counter increments on a rising edge (0->1) of its error input.
  - Counters saturate at 255, reset to 0, and clear on err_clear.
  - Increment and clear in the same cycle gives 1.
  - Rising-edge detection uses one registered copy of each input, reset to 0.
- Undefined: those ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package rx_drain_pkg:
  - state enum (IDLE, READ, WAIT) as a 2-bit typedef;
  - DEFAULT_DEPTH=4;
  - BYTE_W=8.
- Sub-module rx_fifo: parameterised synchronous FIFO (push/pop/full/empty/count/head). rx_drain_ctrl instantiates one rx_fifo plus the FSM and sticky logic.

Test Plan:
- Single byte: rx_data=0xA5, data_ready high 5 cycles then low -> exactly one data_read pulse at cycle+1; out_valid=1, out_data=0xA5; out_ready=1 gives fifo_count back to 0.
- Fill: out_ready=0, 5 bytes 0x01..0x05 with DEPTH=4 -> 0x01..0x04 stored, fifo_count=4, no data_read for 0x05. Raising out_ready then drains 0x01..0x04 in order and 0x05 is captured.
- Overrun: while full, pulse overrun_error -> overrun_sticky=1 and held. err_clear with overrun_error=0 gives 0; err_clear with overrun_error=1 in the same cycle stays 1.
- Framing: framing_error high 10 cycles -> framing_sticky=1, no FIFO write. With RX_DRAIN_ERR_CNT_EN, framing_cnt=1; 300 pulses saturate at 255.
- Simultaneous push/pop: FIFO holds 2 bytes, capture while out_ready=1 -> fifo_count stays 2 and order is preserved across pointer wrap (run for 10 bytes).
- Reset mid-transfer: assert n_rst=0 during READ -> data_read drops immediately, fifo_count=0, out_valid=0, state returns to IDLE.

Source files
------------

// File: rtl/rx_drain_pkg.sv
// Shared types and constants for the UART receive drain controller.
package rx_drain_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int DEFAULT_DEPTH = 4;
  localparam int BYTE_W        = 8;

endpackage

// File: rtl/rx_fifo.sv
// Small synchronous circular FIFO; pointers carry one extra MSB so that
// full and empty can be told apart without a separate counter.
module rx_fifo
  import rx_drain_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1),
  parameter int WIDTH = BYTE_W
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    w_diff;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_diff    = r_wr_ptr - r_rd_ptr;
  assign o_count   = CNT_W'(w_diff);
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/rx_drain_ctrl.sv
// Drains the UART receiver buffer into a FIFO and keeps sticky error status.
// Optional error event counters are enabled with `define RX_DRAIN_ERR_CNT_EN.
module rx_drain_ctrl
  import rx_drain_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              data_ready,
  input  logic              overrun_error,
  input  logic              framing_error,
  output logic              data_read,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  fifo_count,
  input  logic              err_clear,
  output logic              framing_sticky,
  output logic              overrun_sticky
`ifdef RX_DRAIN_ERR_CNT_EN
  ,
  output logic [7:0]        framing_cnt,
  output logic [7:0]        overrun_cnt
`endif
);

  state_t r_state;
  state_t w_next_state;
  logic   r_data_read;
  logic   r_framing_sticky;
  logic   r_overrun_sticky;
  logic   w_push;
  logic   w_pop;
  logic   w_full;
  logic   w_empty;

  rx_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_push      (w_push),
    .i_push_data (rx_data),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (fifo_count),
    .o_head      (out_data)
  );

  assign w_pop          = !w_empty && out_ready;
  assign out_valid      = !w_empty;
  assign data_read      = r_data_read;
  assign framing_sticky = r_framing_sticky;
  assign overrun_sticky = r_overrun_sticky;

  // WAIT holds off until data_ready drops so one byte is never read twice.
  always_comb begin
    w_next_state = r_state;
    w_push       = 1'b0;
    case (r_state)
      IDLE: begin
        if (data_ready && !w_full) begin
          w_push       = 1'b1;
          w_next_state = READ;
        end
      end
      READ:    w_next_state = WAIT;
      WAIT:    if (!data_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_data_read <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_data_read <= (w_next_state == READ);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_framing_sticky <= 1'b0;
      r_overrun_sticky <= 1'b0;
    end else begin
      r_framing_sticky <= framing_error || (r_framing_sticky && !err_clear);
      r_overrun_sticky <= overrun_error || (r_overrun_sticky && !err_clear);
    end
  end

`ifdef RX_DRAIN_ERR_CNT_EN
  logic       r_framing_prev;
  logic       r_overrun_prev;
  logic [7:0] r_framing_cnt;
  logic [7:0] r_overrun_cnt;
  logic       w_framing_rise;
  logic       w_overrun_rise;

  assign w_framing_rise = framing_error && !r_framing_prev;
  assign w_overrun_rise = overrun_error && !r_overrun_prev;
  assign framing_cnt    = r_framing_cnt;
  assign overrun_cnt    = r_overrun_cnt;

  // A clear coinciding with a new edge restarts the count at one.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_framing_prev <= 1'b0;
      r_overrun_prev <= 1'b0;
      r_framing_cnt  <= 8'd0;
      r_overrun_cnt  <= 8'd0;
    end else begin
      r_framing_prev <= framing_error;
      r_overrun_prev <= overrun_error;
      if (err_clear)
        r_framing_cnt <= {7'd0, w_framing_rise};
      else if (w_framing_rise && (r_framing_cnt != 8'hFF))
        r_framing_cnt <= r_framing_cnt + 8'd1;
      if (err_clear)
        r_overrun_cnt <= {7'd0, w_overrun_rise};
      else if (w_overrun_rise && (r_overrun_cnt != 8'hFF))
        r_overrun_cnt <= r_overrun_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rx_drain_ctrl.sv
// Self-checking bench for rx_drain_ctrl: directed steps plus a randomized
// phase, all checked every cycle against a queue-based reference model.
module tb_rx_drain_ctrl;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             n_rst;
  logic [7:0]       rx_data;
  logic             data_ready;
  logic             overrun_error;
  logic             framing_error;
  logic             data_read;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] fifo_count;
  logic             err_clear;
  logic             framing_sticky;
  logic             overrun_sticky;
`ifdef RX_DRAIN_ERR_CNT_EN
  logic [7:0]       framing_cnt;
  logic [7:0]       overrun_cnt;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model: byte queue plus handshake and error bookkeeping.
  logic [7:0] q[$];
  bit         mBlocked, mJustRead, mDataRead, mFs, mOs;
  bit         mPrevF, mPrevO;
  int         mFcnt, mOcnt;

  rx_drain_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .rx_data        (rx_data),
    .data_ready     (data_ready),
    .overrun_error  (overrun_error),
    .framing_error  (framing_error),
    .data_read      (data_read),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .fifo_count     (fifo_count),
    .err_clear      (err_clear),
    .framing_sticky (framing_sticky),
    .overrun_sticky (overrun_sticky)
`ifdef RX_DRAIN_ERR_CNT_EN
    ,
    .framing_cnt    (framing_cnt),
    .overrun_cnt    (overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    q.delete();
    mBlocked  = 0; mJustRead = 0; mDataRead = 0;
    mFs = 0; mOs = 0; mPrevF = 0; mPrevO = 0; mFcnt = 0; mOcnt = 0;
  endtask

  task automatic applyStimulus(input bit dr, input logic [7:0] d, input bit ordy,
                               input bit fe, input bit oe, input bit clr);
    data_ready = dr; rx_data = d; out_ready = ordy;
    framing_error = fe; overrun_error = oe; err_clear = clr;
  endtask

  // Advance one clock, stepping the model and checking every output.
  task automatic tick();
    bit doPush, doPop;
    logic [7:0] captured;
    doPop    = (q.size() != 0) && out_ready;
    doPush   = !mBlocked && data_ready && (q.size() < DEPTH);
    captured = rx_data;
    mDataRead = doPush;
    if (doPush) begin mBlocked = 1; mJustRead = 1; end
    else if (mJustRead) mJustRead = 0;
    else if (mBlocked && !data_ready) mBlocked = 0;
    mFs = framing_error || (mFs && !err_clear);
    mOs = overrun_error || (mOs && !err_clear);
    if (err_clear) mFcnt = (framing_error && !mPrevF) ? 1 : 0;
    else if (framing_error && !mPrevF && mFcnt < 255) mFcnt++;
    if (err_clear) mOcnt = (overrun_error && !mPrevO) ? 1 : 0;
    else if (overrun_error && !mPrevO && mOcnt < 255) mOcnt++;
    mPrevF = framing_error;
    mPrevO = overrun_error;
    @(posedge clk);
    if (doPop) void'(q.pop_front());
    if (doPush) q.push_back(captured);
    #1;
    checkOutput("data_read", 32'(data_read), 32'(mDataRead));
    checkOutput("out_valid", 32'(out_valid), 32'(q.size() != 0));
    checkOutput("out_data", 32'(out_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    checkOutput("fifo_count", 32'(fifo_count), 32'(q.size()));
    checkOutput("framing_sticky", 32'(framing_sticky), 32'(mFs));
    checkOutput("overrun_sticky", 32'(overrun_sticky), 32'(mOs));
`ifdef RX_DRAIN_ERR_CNT_EN
    checkOutput("framing_cnt", 32'(framing_cnt), 32'(mFcnt));
    checkOutput("overrun_cnt", 32'(overrun_cnt), 32'(mOcnt));
`endif
  endtask

  // Emulated receiver: hold data_ready until the byte is taken, then idle.
  task automatic sendByte(input logic [7:0] b, input bit popOnCapture);
    data_ready = 1; rx_data = b;
    for (int i = 0; i < 8; i++) begin
      out_ready = popOnCapture && !mBlocked && (q.size() < DEPTH);
      tick();
      if (mDataRead) break;
    end
    data_ready = 0; out_ready = 0;
    tick();
    tick();
  endtask

  initial begin
    int pulses;
    bit pending;
    n_rst = 0;
    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_data_read", 32'(data_read), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_sticky", {30'd0, framing_sticky, overrun_sticky}, 32'd0);
    n_rst = 1;

    $display("[TB] single byte");
    pulses = 0;
    applyStimulus(1, 8'hA5, 0, 0, 0, 0);
    tick();
    checkOutput("single_first_read", 32'(data_read), 32'd1);
    checkOutput("single_first_data", 32'(out_data), 32'hA5);
    pulses += int'(data_read);
    repeat (4) begin tick(); pulses += int'(data_read); end
    data_ready = 0;
    repeat (2) begin tick(); pulses += int'(data_read); end
    checkOutput("single_pulses", 32'(pulses), 32'd1);
    out_ready = 1;
    tick();
    checkOutput("single_drained", 32'(fifo_count), 32'd0);
    out_ready = 0;

    $display("[TB] fill");
    for (int b = 1; b <= 4; b++) sendByte(8'(b), 0);
    pulses = 0;
    applyStimulus(1, 8'h05, 0, 0, 0, 0);
    repeat (4) begin tick(); pulses += int'(data_read); end
    checkOutput("fill_count", 32'(fifo_count), 32'd4);
    checkOutput("fill_no_read", 32'(pulses), 32'd0);

    $display("[TB] overrun while full");
    overrun_error = 1; tick();
    overrun_error = 0; repeat (3) tick();
    checkOutput("ovr_held", 32'(overrun_sticky), 32'd1);
    err_clear = 1; tick();
    checkOutput("ovr_cleared", 32'(overrun_sticky), 32'd0);
    overrun_error = 1; tick();
    checkOutput("ovr_set_wins", 32'(overrun_sticky), 32'd1);
    overrun_error = 0; tick();
    err_clear = 0;

    pulses = 0;
    out_ready = 1;
    for (int i = 0; i < 14; i++) begin
      tick();
      pulses += int'(data_read);
      if (mDataRead) data_ready = 0;
    end
    checkOutput("drain_fifth_read", 32'(pulses), 32'd1);
    checkOutput("drain_empty", 32'(fifo_count), 32'd0);

    $display("[TB] framing");
    applyStimulus(0, 8'h00, 0, 1, 0, 0);
    repeat (10) tick();
    checkOutput("frm_sticky", 32'(framing_sticky), 32'd1);
    checkOutput("frm_no_write", 32'(fifo_count), 32'd0);
`ifdef RX_DRAIN_ERR_CNT_EN
    checkOutput("frm_cnt_one", 32'(framing_cnt), 32'd1);
    applyStimulus(0, 8'h00, 0, 0, 0, 1);
    tick();
    err_clear = 0;
    repeat (300) begin
      framing_error = 1; tick();
      framing_error = 0; tick();
    end
    checkOutput("frm_cnt_sat", 32'(framing_cnt), 32'd255);
`endif
    applyStimulus(0, 8'h00, 0, 0, 0, 1);
    tick();
    err_clear = 0;

    $display("[TB] simultaneous push/pop");
    sendByte(8'h10, 0);
    sendByte(8'h11, 0);
    checkOutput("pp_preload", 32'(fifo_count), 32'd2);
    for (int k = 0; k < 10; k++) begin
      sendByte(8'(8'h20 + k), 1);
      checkOutput("pp_count", 32'(fifo_count), 32'd2);
    end

    $display("[TB] random");
    pending = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pending && ($urandom_range(0, 3) == 0)) begin
        pending = 1;
        rx_data = 8'($urandom);
        data_ready = 1;
      end
      out_ready     = 1'($urandom_range(0, 1));
      framing_error = ($urandom_range(0, 15) == 0);
      overrun_error = ($urandom_range(0, 15) == 0);
      err_clear     = ($urandom_range(0, 7) == 0);
      tick();
      if (mDataRead) begin pending = 0; data_ready = 0; end
    end

    $display("[TB] reset mid-transfer");
    applyStimulus(0, 8'h00, 1, 0, 0, 1);
    repeat (12) tick();
    applyStimulus(1, 8'h3C, 0, 0, 0, 0);
    tick();
    checkOutput("rst_pre_read", 32'(data_read), 32'd1);
    n_rst = 0;
    #1;
    checkOutput("rst_mid_read", 32'(data_read), 32'd0);
    checkOutput("rst_mid_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);
    modelReset();
    #1;
    n_rst = 1;
    tick();
    checkOutput("rst_post_capture", 32'(data_read), 32'd1);
    data_ready = 0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
